// File: rtl/qam_symbol_mapper.sv
// Collects strobed serial bits into 4-QAM/16-QAM symbols and emits Gray-mapped signed I/Q amplitudes
// over a registered valid/ready interface. Optional macro QAM_SYNC_CLR_EN adds a sync_clr realign input.
module qam_symbol_mapper #(
    parameter int BITS_PER_SYM = 2,
    parameter int AMP_W        = 8,
    parameter int AMP_UNIT     = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    data_in,
    input  logic                    data_strobe,
`ifdef QAM_SYNC_CLR_EN
    input  logic                    sync_clr,
`endif
    output logic signed [AMP_W-1:0] sym_i,
    output logic signed [AMP_W-1:0] sym_q,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic                    overrun,
    output logic [15:0]             sym_count
);

    localparam int CNT_W = (BITS_PER_SYM > 2) ? $clog2(BITS_PER_SYM) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_SYM - 1);
    localparam logic signed [AMP_W-1:0] AMP_1 = AMP_W'(AMP_UNIT);
    localparam logic signed [AMP_W-1:0] AMP_3 = AMP_W'(3 * AMP_UNIT);

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic logic signed [AMP_W-1:0] map_lvl2(input logic b);
        return b ? AMP_1 : -AMP_1;
    endfunction

    // Gray order along the axis: 00, 01, 11, 10 from most negative to most positive.
    function automatic logic signed [AMP_W-1:0] map_lvl4(input logic [1:0] g);
        logic signed [AMP_W-1:0] a;
        case (g)
            2'b00:   a = -AMP_3;
            2'b01:   a = -AMP_1;
            2'b11:   a = AMP_1;
            default: a = AMP_3;
        endcase
        return a;
    endfunction

    logic                      clr;
    logic [BITS_PER_SYM-2:0]   shift_q, shift_d;
    logic [BITS_PER_SYM-1:0]   shift_nxt;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic                      complete;
    logic signed [AMP_W-1:0]   map_i, map_q;
    state_t                    state_q, state_d;
    logic signed [AMP_W-1:0]   sym_i_q, sym_i_d;
    logic signed [AMP_W-1:0]   sym_q_q, sym_q_d;
    logic                      overrun_q, overrun_d;
    logic [15:0]               count_q, count_d;

`ifdef QAM_SYNC_CLR_EN
    assign clr = sync_clr;
`else
    assign clr = 1'b0;
`endif

    // Only the first BITS_PER_SYM-1 bits need storing; the last bit is consumed straight from data_in.
    assign shift_nxt = {shift_q, data_in};

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        complete  = 1'b0;
        if (clr) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (data_strobe) begin
            shift_d = shift_nxt[BITS_PER_SYM-2:0];
            if (bit_cnt_q == LAST_BIT) begin
                complete  = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    if (BITS_PER_SYM == 4) begin : g_qam16
        assign map_i = map_lvl4(shift_nxt[3:2]);
        assign map_q = map_lvl4(shift_nxt[1:0]);
    end else begin : g_qam4
        assign map_i = map_lvl2(shift_nxt[1]);
        assign map_q = map_lvl2(shift_nxt[0]);
    end

    always_comb begin
        state_d   = state_q;
        sym_i_d   = sym_i_q;
        sym_q_d   = sym_q_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    sym_i_d = map_i;
                    sym_q_d = map_q;
                    state_d = FULL;
                end
            end
            default: begin
                if (sym_ready) begin
                    count_d = count_q + 16'd1;
                    if (complete) begin
                        sym_i_d = map_i;
                        sym_q_d = map_q;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (complete) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= EMPTY;
            sym_i_q   <= '0;
            sym_q_q   <= '0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            state_q   <= state_d;
            sym_i_q   <= sym_i_d;
            sym_q_q   <= sym_q_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign sym_i     = sym_i_q;
    assign sym_q     = sym_q_q;
    assign sym_valid = (state_q == FULL);
    assign overrun   = overrun_q;
    assign sym_count = count_q;

endmodule
